clock_digit: RTL and testbench
==============================

Name: clock_digit

Overview:
- Single decimal digit of a cascadable time-of-day counter (HH:MM:SS).
- Holds one value from 0 to a parameterised limit.
- Increments on a one-cycle enable pulse and wraps to 0, asserting a combinational overflow that feeds the next-more-significant digit's increment.
- Supports a synchronous parallel load (time set from a decoded time source) and an alternate limit selected by a neighbour digit (hours LSD limited to 3 when hours MSD is 2).

Parameters:
- MAX, 9, normal maximum digit value (wrap point); 2, 5 or 9 in the clock.
- MAX2, MAX, alternate maximum used while at_max_i=1; must be <= MAX.
- WIDTH, $clog2(MAX+1) (minimum 1), derived localparam; width of digit_o and load_value_i (MAX=2→2, MAX=5→3, MAX=9→4).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- inc_i  in  1  increment request, one-cycle pulse, sampled on the clock edge.
- ovf_o  out  1  combinational wrap indicator = inc_i & ~load_i & at_limit; drives the next digit's inc_i.
- at_max_i  in  1  selects MAX2 as the limit when 1; tie 0 when unused.
- at_max_o  out  1  combinational, 1 when digit_o >= MAX; feeds a dependent digit's at_max_i.
- load_i  in  1  synchronous load strobe.
- load_value_i  in  WIDTH  value captured when load_i=1.
- digit_o  out  WIDTH  current registered digit value.

Behaviour:
- Reset: while rst_i=0, digit_o=0 immediately, independent of the clock. ovf_o=0 and at_max_o=0 follow combinationally from the reset state. Reset release has no side effects.
- limit = at_max_i ? MAX2 : MAX.
- at_limit = (digit_o >= limit). ">=" makes out-of-range values (e.g. a loaded 5 when the limit drops to 3) wrap rather than count up.
- Priority on each rising edge, reset excluded:
  1. load_i=1: digit_o <= load_value_i. inc_i is ignored and ovf_o=0.
  2. else inc_i=1 and at_limit: digit_o <= 0; ovf_o=1 during that cycle.
  3. else inc_i=1: digit_o <= digit_o + 1.
  4. else: hold.
- Load values are stored unmodified, with no clamping. A value > limit wraps to 0 with ovf on the next inc.
- ovf_o and at_max_o are purely combinational (no register). A full carry chain ripples in the same cycle as the least-significant inc_i, so six digits update atomically on one edge.
- No combinational path from ovf_o back to inc_i within a digit. Combinational loops are avoided in cascades because at_max_o depends only on state.
- at_max_i may change in the same cycle as inc_i; the value sampled at the edge decides the limit.
- Latency: digit_o changes one clock after the inc_i/load_i sampled edge. ovf_o has zero latency relative to inc_i.

Test Plan:
- Reset: hold rst_i=0 mid-count (digit=7, MAX=9) → digit_o=0 asynchronously before the next edge, ovf_o=0; release, no spurious change.
- Count/wrap MAX=9: ten inc pulses from 0 → 1..9 then 0; ovf_o=1 only during the 10th pulse cycle; at_max_o=1 only while digit_o=9.
- Alternate limit MAX=9, MAX2=3: at_max_i=1, digit 3, inc → digit 0, ovf_o=1. Same with at_max_i=0 → digit 4, ovf_o=0. Loaded 5 with at_max_i=1, inc → 0, ovf_o=1.
- Load priority: digit 2, load_i=1, load_value_i=6, inc_i=1 simultaneously → digit_o=6 next cycle, ovf_o=0 that cycle; load with inc_i=0 and digit at 9 → no ovf.
- Six-digit cascade (limits 2/9(3)/5/9/5/9): load 23:59:59, one inc → 00:00:00 on the same edge, top ovf_o pulsed for exactly one cycle. Load 19:59:59, inc → 20:00:00 with no top ovf.
- Idle: inc_i=0, load_i=0 for 100 cycles at digit 4 → digit_o stays 4, ovf_o=0.

Source files
------------

// File: rtl/clock_digit.sv
// -----------------------------------------------------------------------------
// clock_digit
//
// One decimal digit of a cascadable time-of-day counter (HH:MM:SS). The digit
// counts from 0 up to a limit and then wraps to 0. On the wrap it raises a
// combinational overflow that drives the next-more-significant digit's
// increment. A full chain of digits therefore ripples its carry within the
// same cycle and updates atomically on a single clock edge.
//
// The limit is MAX. When a neighbour digit asserts at_max_i, the limit is
// MAX2 instead. An example is the hours LSD, which is limited to 3 while the
// hours MSD is 2.
//
// Parameters
//   MAX    normal maximum digit value (wrap point)
//   MAX2   alternate maximum used while at_max_i=1 (must be <= MAX)
//   WIDTH  derived width of digit_o / load_value_i
//
// Ports
//   clk_i         clock; all state updates on the rising edge
//   rst_i         asynchronous, active-low reset (digit_o -> 0)
//   inc_i         one-cycle increment request
//   ovf_o         combinational wrap indicator: inc_i & ~load_i & at_limit
//   at_max_i      selects MAX2 as the limit when 1 (tie 0 when unused)
//   at_max_o      combinational: 1 while digit_o >= MAX
//   load_i        synchronous parallel-load strobe (overrides inc_i)
//   load_value_i  value captured unmodified when load_i=1
//   digit_o       current registered digit value
// -----------------------------------------------------------------------------
module clock_digit #(
    parameter int  MAX   = 9,
    parameter int  MAX2  = MAX,
    localparam int WIDTH = (MAX < 2) ? 1 : $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic             ovf_o,
    input  logic             at_max_i,
    output logic             at_max_o,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] digit_o
);

    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MAX2_W = WIDTH'(MAX2);

    logic [WIDTH-1:0] digit_q;
    logic [WIDTH-1:0] digit_d;
    logic [WIDTH-1:0] limit;
    logic             at_limit;

    // at_max_i is sampled together with inc_i, so a neighbour that changes
    // in the same cycle decides the limit for this edge.
    assign limit = at_max_i ? MAX2_W : MAX_W;

    // Use ">=" rather than "==". A loaded value above the current limit
    // (e.g. 5 while the hours LSD is limited to 3) then wraps on the next
    // increment instead of counting further out of range.
    assign at_limit = (digit_q >= limit);

    // Both status outputs are purely combinational. at_max_o depends only on
    // state, so chaining it into a neighbour's at_max_i cannot form a loop.
    assign ovf_o    = inc_i & ~load_i & at_limit;
    assign at_max_o = (digit_q >= MAX_W);

    // NOTE: digit_d gets its default first. Every path through the block then
    // assigns it, so no latch is inferred.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_value_i;
        end else if (inc_i) begin
            digit_d = at_limit ? '0 : digit_q + WIDTH'(1);
        end
    end

    // NOTE: state is written with non-blocking assignments only. The
    // asynchronous reset clears the digit immediately, without a clock edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: tb/tb_clock_digit.sv
module tb_clock_digit;

    int n_cmp  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- single digit, MAX=9, MAX2=3 ----------------
    logic       inc = 1'b0, load = 1'b0, at_max_in = 1'b0;
    logic [3:0] load_val = '0;
    logic       ovf, at_max_out;
    logic [3:0] digit;

    clock_digit #(.MAX(9), .MAX2(3)) dut (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .ovf_o(ovf),
        .at_max_i(at_max_in), .at_max_o(at_max_out),
        .load_i(load), .load_value_i(load_val), .digit_o(digit)
    );

    // ---------------- six-digit cascade HH:MM:SS ----------------
    logic       c_inc = 1'b0, c_load = 1'b0;
    logic [1:0] lv_h10 = '0;
    logic [3:0] lv_h1 = '0, lv_m1 = '0, lv_s1 = '0;
    logic [2:0] lv_m10 = '0, lv_s10 = '0;
    logic [1:0] d_h10;
    logic [3:0] d_h1, d_m1, d_s1;
    logic [2:0] d_m10, d_s10;
    logic ovf_s1, ovf_s10, ovf_m1, ovf_m10, ovf_h1, ovf_h10;
    logic am_h10, am_h1, am_m10, am_m1, am_s10, am_s1;

    clock_digit #(.MAX(9)) u_s1 (
        .clk_i(clk), .rst_i(rst), .inc_i(c_inc), .ovf_o(ovf_s1),
        .at_max_i(1'b0), .at_max_o(am_s1),
        .load_i(c_load), .load_value_i(lv_s1), .digit_o(d_s1)
    );
    clock_digit #(.MAX(5)) u_s10 (
        .clk_i(clk), .rst_i(rst), .inc_i(ovf_s1), .ovf_o(ovf_s10),
        .at_max_i(1'b0), .at_max_o(am_s10),
        .load_i(c_load), .load_value_i(lv_s10), .digit_o(d_s10)
    );
    clock_digit #(.MAX(9)) u_m1 (
        .clk_i(clk), .rst_i(rst), .inc_i(ovf_s10), .ovf_o(ovf_m1),
        .at_max_i(1'b0), .at_max_o(am_m1),
        .load_i(c_load), .load_value_i(lv_m1), .digit_o(d_m1)
    );
    clock_digit #(.MAX(5)) u_m10 (
        .clk_i(clk), .rst_i(rst), .inc_i(ovf_m1), .ovf_o(ovf_m10),
        .at_max_i(1'b0), .at_max_o(am_m10),
        .load_i(c_load), .load_value_i(lv_m10), .digit_o(d_m10)
    );
    clock_digit #(.MAX(9), .MAX2(3)) u_h1 (
        .clk_i(clk), .rst_i(rst), .inc_i(ovf_m10), .ovf_o(ovf_h1),
        .at_max_i(am_h10), .at_max_o(am_h1),
        .load_i(c_load), .load_value_i(lv_h1), .digit_o(d_h1)
    );
    clock_digit #(.MAX(2)) u_h10 (
        .clk_i(clk), .rst_i(rst), .inc_i(ovf_h1), .ovf_o(ovf_h10),
        .at_max_i(1'b0), .at_max_o(am_h10),
        .load_i(c_load), .load_value_i(lv_h10), .digit_o(d_h10)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; combinational outputs are
    // sampled at the following falling edge; registers 1 unit after the next
    // rising edge.
    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_post_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic int clock_seconds();
        return int'(d_h10) * 36000 + int'(d_h1) * 3600 + int'(d_m10) * 600 +
               int'(d_m1) * 60 + int'(d_s10) * 10 + int'(d_s1);
    endfunction

    task automatic cascade_load(input int t);
        lv_h10 = 2'((t / 36000));
        lv_h1  = 4'((t / 3600) % 10);
        lv_m10 = 3'((t % 3600) / 600);
        lv_m1  = 4'((t % 600) / 60);
        lv_s10 = 3'((t % 60) / 10);
        lv_s1  = 4'(t % 10);
        c_load = 1'b1;
        c_inc  = 1'b0;
        to_post_edge();
        c_load = 1'b0;
    endtask

    task automatic single_load(input int v);
        load = 1'b1; load_val = 4'(v); inc = 1'b0;
        to_post_edge();
        load = 1'b0;
    endtask

    typedef struct {
        logic load;
        int   val;
        logic inc;
        logic at_max;
        logic exp_ovf;
        int   exp_digit;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int exp_d;
        int lim;
        int t;
        logic e_ovf;

        // ---------- reset state ----------
        #2;
        check("reset_digit", int'(digit), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_at_max", int'(at_max_out), 0);
        check("reset_cascade", clock_seconds(), 0);
        to_mid();
        rst = 1'b1;
        to_post_edge();
        check("release_digit", int'(digit), 0);

        // ---------- table-driven vectors (state carries from row to row) ----------
        vecs[0]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b1, 3,  1'b0, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, 0};   // alt limit wraps at 3
        vecs[3]  = '{1'b1, 3,  1'b0, 1'b0, 1'b0, 3};
        vecs[4]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 4};   // normal limit counts on
        vecs[5]  = '{1'b1, 5,  1'b0, 1'b1, 1'b0, 5};
        vecs[6]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, 0};   // loaded 5 > alt limit
        vecs[7]  = '{1'b1, 2,  1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b1, 6,  1'b1, 1'b0, 1'b0, 6};   // load beats inc
        vecs[9]  = '{1'b1, 9,  1'b0, 1'b0, 1'b0, 9};
        vecs[10] = '{1'b1, 9,  1'b0, 1'b0, 1'b0, 9};   // load at 9, no ovf
        vecs[11] = '{1'b1, 4,  1'b1, 1'b0, 1'b0, 4};   // load+inc at limit, no ovf
        vecs[12] = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 4};   // hold
        vecs[13] = '{1'b1, 15, 1'b0, 1'b0, 1'b0, 15};  // stored without clamping
        vecs[14] = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 0};   // out-of-range wraps
        exp_d = 0;
        for (int i = 0; i < 15; i++) begin
            load = vecs[i].load; load_val = 4'(vecs[i].val);
            inc = vecs[i].inc; at_max_in = vecs[i].at_max;
            to_mid();
            check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_at_max", i), int'(at_max_out), (exp_d >= 9) ? 1 : 0);
            to_post_edge();
            check($sformatf("vec%0d_digit", i), int'(digit), vecs[i].exp_digit);
            exp_d = vecs[i].exp_digit;
        end
        load = 1'b0; inc = 1'b0; at_max_in = 1'b0;

        // ---------- count and wrap: ten pulses from 0 ----------
        single_load(0);
        for (int k = 1; k <= 10; k++) begin
            inc = 1'b1;
            to_mid();
            check($sformatf("cnt%0d_ovf", k), int'(ovf), (k == 10) ? 1 : 0);
            check($sformatf("cnt%0d_at_max", k), int'(at_max_out), (k == 10) ? 1 : 0);
            to_post_edge();
            inc = 1'b0;
            check($sformatf("cnt%0d_digit", k), int'(digit), k % 10);
        end

        // ---------- asynchronous reset mid-count ----------
        single_load(7);
        to_mid();
        rst = 1'b0;
        #1;
        check("async_rst_digit", int'(digit), 0);
        check("async_rst_ovf", int'(ovf), 0);
        #2;
        rst = 1'b1;
        to_post_edge();
        to_post_edge();
        check("rst_release_digit", int'(digit), 0);

        // ---------- idle for 100 cycles ----------
        single_load(4);
        begin
            int bad_d = 0, bad_o = 0;
            for (int k = 0; k < 100; k++) begin
                to_mid();
                if (ovf !== 1'b0) bad_o++;
                to_post_edge();
                if (digit !== 4'd4) bad_d++;
            end
            check("idle_digit_changes", bad_d, 0);
            check("idle_ovf_pulses", bad_o, 0);
            check("idle_digit", int'(digit), 4);
        end

        // ---------- cascade corner cases ----------
        cascade_load(23 * 3600 + 59 * 60 + 59);
        check("casc_load_2359", clock_seconds(), 86399);
        c_inc = 1'b1;
        to_mid();
        check("casc_midnight_top_ovf", int'(ovf_h10), 1);
        to_post_edge();
        c_inc = 1'b0;
        check("casc_midnight_time", clock_seconds(), 0);
        to_mid();
        check("casc_top_ovf_one_cycle", int'(ovf_h10), 0);

        cascade_load(19 * 3600 + 59 * 60 + 59);
        c_inc = 1'b1;
        to_mid();
        check("casc_19_top_ovf", int'(ovf_h10), 0);
        to_post_edge();
        c_inc = 1'b0;
        check("casc_19_to_20", clock_seconds(), 20 * 3600);

        // ---------- random single digit vs. reference ----------
        single_load(0);
        exp_d = 0;
        for (int k = 0; k < 300; k++) begin
            load      = ($urandom_range(0, 7) == 0);
            load_val  = 4'($urandom_range(0, 15));
            inc       = 1'($urandom_range(0, 1));
            at_max_in = 1'($urandom_range(0, 1));
            lim   = at_max_in ? 3 : 9;
            e_ovf = inc && !load && (exp_d >= lim);
            to_mid();
            check("rnd_ovf", int'(ovf), int'(e_ovf));
            check("rnd_at_max", int'(at_max_out), (exp_d >= 9) ? 1 : 0);
            to_post_edge();
            if (load)       exp_d = int'(load_val);
            else if (inc)   exp_d = (exp_d >= lim) ? 0 : exp_d + 1;
            check("rnd_digit", int'(digit), exp_d);
        end
        load = 1'b0; inc = 1'b0; at_max_in = 1'b0;

        // ---------- random cascade vs. seconds-of-day model ----------
        for (int r = 0; r < 8; r++) begin
            t = (r % 2 == 0) ? 86400 - int'($urandom_range(1, 20))
                             : int'($urandom_range(0, 86399));
            cascade_load(t);
            check("rnd_casc_load", clock_seconds(), t);
            for (int k = 0; k < 40; k++) begin
                c_inc = 1'($urandom_range(0, 1));
                to_mid();
                check("rnd_casc_top_ovf", int'(ovf_h10), (c_inc && t == 86399) ? 1 : 0);
                to_post_edge();
                if (c_inc) t = (t + 1) % 86400;
                c_inc = 1'b0;
                check("rnd_casc_time", clock_seconds(), t);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
